// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit: default
// parameters and the next-PC source encoding.
package pc_pkg;

    localparam int          DEF_ADDR_W       = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEF_INSTR_BYTES  = 4;
    localparam int          DEF_RAS_DEPTH    = 4;

    // Alignment shift for the default instruction size.
    localparam int          ALIGN_SHIFT      = $clog2(DEF_INSTR_BYTES);

    typedef enum logic [2:0] {
        SRC_TRAP   = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_HOLD   = 3'd2,
        SRC_RAS    = 3'd3,
        SRC_SEQ    = 3'd4
    } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, push+pop replace (tail call),
// clear, top-of-stack read and entry count. Overflow overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          wdata,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(RAS_DEPTH):0] count
);

    localparam int             PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  ptr_n_s;
    logic [PTR_W-1:0]  top_idx_s;
    logic [PTR_W-1:0]  wr_idx_s;
    logic [PTR_W:0]    count_r;
    logic [PTR_W:0]    count_n_s;
    logic              wr_en_s;
    logic              empty_s;

    assign top_idx_s = ptr_r - PTR_ONE;
    assign empty_s   = (count_r == CNT_ZERO);

    // Next pointer/count and write port selection.
    always_comb begin
        ptr_n_s   = ptr_r;
        count_n_s = count_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        if (clear) begin
            ptr_n_s   = PTR_ZERO;
            count_n_s = CNT_ZERO;
        end else if (push && pop && !empty_s) begin
            // Tail call: the popped top is replaced in place.
            wr_en_s  = 1'b1;
            wr_idx_s = top_idx_s;
        end else if (push) begin
            wr_en_s   = 1'b1;
            ptr_n_s   = ptr_r + PTR_ONE;
            count_n_s = (count_r == CNT_FULL) ? count_r : (count_r + CNT_ONE);
        end else if (pop && !empty_s) begin
            ptr_n_s   = top_idx_s;
            count_n_s = count_r - CNT_ONE;
        end else begin
            ptr_n_s   = ptr_r;
            count_n_s = count_r;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            ptr_r   <= ptr_n_s;
            count_r <= count_n_s;
        end
    end

    // Entry storage; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wdata;
        end
    end

    assign top   = mem_r[top_idx_s];
    assign count = count_r;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: valid/ready fetch handshake with stall,
// prioritised trap/branch redirects and return-address prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter int                INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter int                RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       trap_valid,
    input  logic [ADDR_W-1:0]          trap_target,
    input  logic                       br_taken,
    input  logic [ADDR_W-1:0]          br_target,
    input  logic                       ras_push,
    input  logic                       ras_pop,
    input  logic                       fetch_ready,
    output logic [ADDR_W-1:0]          pc_out,
    output logic                       fetch_valid,
    output logic                       ras_empty,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    localparam int                CNT_W      = $clog2(RAS_DEPTH) + 1;
    localparam int                ALIGN_W    = $clog2(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_W;
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);

    logic              valid_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_n_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic [CNT_W-1:0]  ras_count_s;
    logic              fire_s;
    logic              ras_en_s;
    next_src_e         src_s;

    assign fetch_valid = valid_r & ~stall;
    assign fire_s      = fetch_valid & fetch_ready;
    assign seq_pc_s    = pc_r + PC_INC;
    // Stack only moves on an accepted fetch that is not being redirected.
    assign ras_en_s    = fire_s & ~trap_valid & ~br_taken;

    // Next-PC source priority.
    always_comb begin
        src_s = SRC_HOLD;
        if (trap_valid) begin
            src_s = SRC_TRAP;
        end else if (br_taken) begin
            src_s = SRC_BRANCH;
        end else if (!fire_s) begin
            src_s = SRC_HOLD;
        end else if (ras_pop && !ras_empty) begin
            src_s = SRC_RAS;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next-PC value for the selected source.
    always_comb begin
        pc_n_s = pc_r;
        case (src_s)
            SRC_TRAP:   pc_n_s = trap_target & ALIGN_MASK;
            SRC_BRANCH: pc_n_s = br_target & ALIGN_MASK;
            SRC_HOLD:   pc_n_s = pc_r;
            SRC_RAS:    pc_n_s = ras_top_s & ALIGN_MASK;
            SRC_SEQ:    pc_n_s = seq_pc_s;
            default:    pc_n_s = pc_r;
        endcase
    end

    // PC and fetch-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_VECTOR & ALIGN_MASK;
            valid_r <= 1'b0;
        end else begin
            pc_r    <= pc_n_s;
            valid_r <= 1'b1;
        end
    end

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .clear (trap_valid),
        .push  (ras_en_s & ras_push),
        .pop   (ras_en_s & ras_pop),
        .wdata (seq_pc_s),
        .top   (ras_top_s),
        .count (ras_count_s)
    );

    assign pc_out    = pc_r;
    assign ras_count = ras_count_s;
    assign ras_empty = (ras_count_s == {CNT_W{1'b0}});

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random stimulus,
// compared every cycle against a queue-based reference model.
module tb_pc_gen;
    import pc_pkg::*;

    localparam int          AW    = 32;
    localparam logic [31:0] RV    = 32'h0000_1000;
    localparam int          IB    = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = ~(32'(IB) - 32'd1);

    logic        clk = 1'b0;
    logic        rst, stall, trap_valid, br_taken, ras_push, ras_pop, fetch_ready;
    logic [31:0] trap_target, br_target;
    logic [31:0] pc_out;
    logic        fetch_valid, ras_empty;
    logic [2:0]  ras_count;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_W       (AW),
        .RESET_VECTOR (RV),
        .INSTR_BYTES  (IB),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ras_push    (ras_push),
        .ras_pop     (ras_pop),
        .fetch_ready (fetch_ready),
        .pc_out      (pc_out),
        .fetch_valid (fetch_valid),
        .ras_empty   (ras_empty),
        .ras_count   (ras_count)
    );

    int          nchk = 0;
    int          nerr = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc = RV & MASK;
    bit          m_valid = 1'b0;
    logic [31:0] m_q[$];            // back of queue = top of stack

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: derive next state from the current inputs, then advance one edge.
    task automatic step();
        logic [31:0] n_pc;
        bit          n_valid;
        logic [31:0] n_q[$];
        logic [31:0] seq;
        bit          fire;
        next_src_e   src;
        n_q     = m_q;
        n_pc    = m_pc;
        n_valid = m_valid;
        seq     = m_pc + 32'(IB);
        fire    = m_valid && !stall && fetch_ready;
        if (trap_valid)                      src = SRC_TRAP;
        else if (br_taken)                   src = SRC_BRANCH;
        else if (!fire)                      src = SRC_HOLD;
        else if (ras_pop && n_q.size() > 0)  src = SRC_RAS;
        else                                 src = SRC_SEQ;
        if (rst) begin
            n_pc = RV & MASK; n_valid = 1'b0; n_q.delete();
        end else begin
            n_valid = 1'b1;
            case (src)
                SRC_TRAP:   begin n_pc = trap_target & MASK; n_q.delete(); end
                SRC_BRANCH: n_pc = br_target & MASK;
                SRC_RAS: begin
                    n_pc = n_q[n_q.size()-1];
                    if (ras_push) n_q[n_q.size()-1] = seq;
                    else void'(n_q.pop_back());
                end
                SRC_SEQ: begin
                    n_pc = seq;
                    if (ras_push) begin
                        n_q.push_back(seq);
                        if (n_q.size() > DEPTH) void'(n_q.pop_front());
                    end
                end
                default: n_pc = m_pc;
            endcase
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_valid = n_valid; m_q = n_q;
        chk_en = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] addr);
        br_taken = 1'b1; br_target = addr;
        step();
        br_taken = 1'b0;
    endtask

    task automatic fire_op(input bit psh, input bit pp);
        ras_push = psh; ras_pop = pp;
        step();
        ras_push = 1'b0; ras_pop = 1'b0;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc_out", pc_out, m_pc);
            cmp("fetch_valid", 32'(fetch_valid), 32'(m_valid & ~stall));
            cmp("ras_count", 32'(ras_count), 32'(m_q.size()));
            cmp("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
        end
    end

    initial begin
        logic [31:0] calls [5];
        logic [31:0] rets  [4];
        calls = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
        rets  = '{32'hE4, 32'hD4, 32'hC4, 32'hB4};
        rst = 1'b1; stall = 1'b0; trap_valid = 1'b0; br_taken = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0; fetch_ready = 1'b0;
        trap_target = 32'h0; br_target = 32'h0;

        // Reset and sequential fetch
        step(); step();
        cmp("rst_pc", pc_out, 32'h1000);
        cmp("rst_fv", 32'(fetch_valid), 32'd0);
        cmp("rst_cnt", 32'(ras_count), 32'd0);
        cmp("rst_empty", 32'(ras_empty), 32'd1);
        rst = 1'b0; fetch_ready = 1'b1;
        step();
        cmp("first_fv", 32'(fetch_valid), 32'd1);
        cmp("first_pc", pc_out, 32'h1000);
        step(); cmp("seq1", pc_out, 32'h1004);
        step(); cmp("seq2", pc_out, 32'h1008);
        step(); cmp("seq3", pc_out, 32'h100C);

        // Backpressure, then trap beats branch while stalled
        fetch_ready = 1'b0;
        repeat (3) step();
        cmp("hold", pc_out, 32'h100C);
        fetch_ready = 1'b1;
        fire_op(1'b1, 1'b0);
        cmp("push_cnt", 32'(ras_count), 32'd1);
        fetch_ready = 1'b0; stall = 1'b1;
        trap_valid = 1'b1; trap_target = 32'h80; br_taken = 1'b1; br_target = 32'h200;
        step();
        trap_valid = 1'b0; br_taken = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        cmp("trap_pc", pc_out, 32'h80);
        cmp("trap_cnt", 32'(ras_count), 32'd0);

        // Call / return
        redirect(32'h100); fire_op(1'b1, 1'b0);
        redirect(32'h300); fire_op(1'b1, 1'b0);
        cmp("call_cnt", 32'(ras_count), 32'd2);
        redirect(32'h500); fire_op(1'b0, 1'b1);
        cmp("ret1_pc", pc_out, 32'h304);
        cmp("ret1_cnt", 32'(ras_count), 32'd1);
        fire_op(1'b0, 1'b1);
        cmp("ret2_pc", pc_out, 32'h104);
        cmp("ret2_empty", 32'(ras_empty), 32'd1);

        // Overflow and underflow
        for (int i = 0; i < 5; i++) begin
            redirect(calls[i]); fire_op(1'b1, 1'b0);
        end
        cmp("ovf_cnt", 32'(ras_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            fire_op(1'b0, 1'b1);
            cmp("ovf_pop", pc_out, rets[i]);
        end
        fire_op(1'b0, 1'b1);
        cmp("unf_pc", pc_out, 32'hB8);
        cmp("unf_cnt", 32'(ras_count), 32'd0);

        // Tail call
        redirect(32'h200); fire_op(1'b1, 1'b0);
        redirect(32'h400); fire_op(1'b1, 1'b1);
        cmp("tail_pc", pc_out, 32'h204);
        cmp("tail_cnt", 32'(ras_count), 32'd1);
        fire_op(1'b0, 1'b1);
        cmp("tail_top", pc_out, 32'h404);

        // Edge cases: wrap, misaligned target, reset beating trap
        redirect(32'hFFFF_FFFC); fire_op(1'b0, 1'b0);
        cmp("wrap", pc_out, 32'h0);
        redirect(32'h123);
        cmp("align", pc_out, 32'h120);
        fire_op(1'b1, 1'b0);
        rst = 1'b1; trap_valid = 1'b1; trap_target = 32'h80;
        step();
        cmp("rst_trap_pc", pc_out, 32'h1000);
        cmp("rst_trap_cnt", 32'(ras_count), 32'd0);
        rst = 1'b0; trap_valid = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            trap_valid  = ($urandom_range(0, 49) == 0);
            br_taken    = ($urandom_range(0, 11) == 0);
            trap_target = $urandom;
            br_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9 : $urandom;
            ras_push    = ($urandom_range(0, 2) == 0);
            ras_pop     = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
